// File: rtl/uwasic_spi_pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : uwasic_spi_pwm_peripheral
//  Description : Write-only SPI (mode 0) register bank driving a 16-pin
//                output block. Each pin can be held low, held high, or
//                driven by a shared ~3 kHz PWM waveform.
//  Revision    : 1.0 - initial release
// ============================================================================
module uwasic_spi_pwm_peripheral #(
    parameter int PWM_CLK_DIV = 13,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset despite the name
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int c_PRE_W = (PWM_CLK_DIV > 1) ? $clog2(PWM_CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PWM_CLK_DIV - 1);
    localparam logic [4:0] c_FRAME_BITS = 5'd16;
    localparam logic [4:0] c_CNT_MAX    = 5'd31;

    // ------------------------------------------------------------------------
    // Input synchronisers (stage [1] is the synchronised value, [2] the
    // previous value used for edge detection)
    // ------------------------------------------------------------------------
    logic [2:0] r_sclk_sync;
    logic [1:0] r_copi_sync;
    logic [2:0] r_ncs_sync;

    // Shift the raw pins through their synchroniser chains
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], ui_in[0]};
            r_copi_sync <= {r_copi_sync[0], ui_in[1]};
            r_ncs_sync  <= {r_ncs_sync[1:0], ui_in[2]};
        end
    end

    logic w_sclk_rise;
    logic w_ncs_fall;
    logic w_ncs_rise;
    logic w_ncs_active;
    logic w_copi;

    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_ncs_fall   = ~r_ncs_sync[1] & r_ncs_sync[2];
    assign w_ncs_rise   = r_ncs_sync[1] & ~r_ncs_sync[2];
    assign w_ncs_active = ~r_ncs_sync[1];
    assign w_copi       = r_copi_sync[1];

    // ------------------------------------------------------------------------
    // SPI receive shift register and bit counter
    // ------------------------------------------------------------------------
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;   // saturates so long frames can never alias to 16

    // Capture COPI on SCLK rising edges while selected; nCS fall starts a frame
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_ncs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_ncs_active && w_sclk_rise) begin
            r_shift <= {r_shift[14:0], w_copi};
            if (r_bit_cnt != c_CNT_MAX) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    logic [6:0] w_addr;
    logic       w_commit;

    assign w_addr   = r_shift[14:8];
    assign w_commit = w_ncs_rise && (r_bit_cnt == c_FRAME_BITS) && r_shift[15]
                      && (w_addr < 7'(NUM_REGS));

    // ------------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------------
    logic [15:0] r_en_out;
    logic [15:0] r_pwm_en;
    logic [7:0]  r_duty;

    // Commit a complete, valid write frame on the nCS rising edge
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_en_out <= '0;
            r_pwm_en <= '0;
            r_duty   <= '0;
        end else if (w_commit) begin
            case (w_addr)
                7'd0:    r_en_out[7:0]  <= r_shift[7:0];
                7'd1:    r_en_out[15:8] <= r_shift[7:0];
                7'd2:    r_pwm_en[7:0]  <= r_shift[7:0];
                7'd3:    r_pwm_en[15:8] <= r_shift[7:0];
                7'd4:    r_duty         <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // PWM timebase: prescaler feeding a free-running 8-bit counter
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_prescale;
    logic [7:0]         r_pwm_cnt;

    // Advance the PWM counter once every PWM_CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_prescale <= '0;
            r_pwm_cnt  <= '0;
        end else if (r_prescale == c_PRE_LAST) begin
            r_prescale <= '0;
            r_pwm_cnt  <= r_pwm_cnt + 8'd1;
        end else begin
            r_prescale <= r_prescale + c_PRE_W'(1);
        end
    end

    // Full-scale duty is forced high so 0xFF really means 100 %
    logic w_pwm_sig;
    assign w_pwm_sig = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
    logic [15:0] r_out;

    // Per pin: disabled -> 0, enabled static -> 1, enabled PWM -> waveform
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= r_en_out & (~r_pwm_en | {16{w_pwm_sig}});
        end
    end

    assign uo_out  = r_out[7:0];
    assign uio_out = r_out[15:8];
    assign uio_oe  = 8'hFF;

    // Tile select, bidirectional inputs and spare ui_in pins carry no function
    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_uwasic_spi_pwm_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uwasic_spi_pwm_peripheral
//  Description : Self-checking bench: directed and randomized SPI frames
//                against a register-level reference model; PWM checked by
//                period, high time and per-pin high counts over one period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uwasic_spi_pwm_peripheral;

    localparam int c_PER = 13 * 256;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    uwasic_spi_pwm_peripheral #(
        .PWM_CLK_DIV(13),
        .NUM_REGS   (5)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents as the specification defines them
    logic [15:0] m_en;
    logic [15:0] m_pwm;
    logic [7:0]  m_duty;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] frm(input logic rw, input logic [6:0] addr,
                                        input logic [7:0] data);
        return {16'h0, rw, addr, data};
    endfunction

    task automatic m_apply(input logic [31:0] bits, input int n);
        if (n == 16 && bits[15] && bits[14:8] < 7'd5) begin
            case (bits[14:8])
                7'd0: m_en[7:0]   = bits[7:0];
                7'd1: m_en[15:8]  = bits[7:0];
                7'd2: m_pwm[7:0]  = bits[7:0];
                7'd3: m_pwm[15:8] = bits[7:0];
                default: m_duty   = bits[7:0];
            endcase
        end
    endtask

    task automatic spi_bit(input logic b);
        ui_in[1] = b;
        repeat (4) @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        ui_in[0] = 1'b0;
    endtask

    // Send the low n bits of 'bits', MSB first, as one framed transaction
    task automatic send_frame(input logic [31:0] bits, input int n);
        ui_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = n - 1; k >= 0; k--) spi_bit(bits[k]);
        repeat (4) @(negedge clk);
        ui_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        m_apply(bits, n);
    endtask

    // Deterministic pins compared directly; PWM pins at mid duty are masked
    task automatic check_static(input string tag);
        logic [15:0] var_mask;
        logic [15:0] exp;
        var_mask = (m_duty != 8'h00 && m_duty != 8'hFF) ? (m_en & m_pwm) : 16'h0;
        exp      = m_en & (~m_pwm | {16{m_duty == 8'hFF}});
        chk(tag, {16'h0, {uio_out, uo_out} & ~var_mask}, {16'h0, exp & ~var_mask});
    endtask

    // Over any one full PWM period each pin is high exactly duty*13 clocks
    task automatic check_counts(input string tag);
        int cnt [16];
        int exp;
        for (int b = 0; b < 16; b++) cnt[b] = 0;
        for (int t = 0; t < c_PER; t++) begin
            @(negedge clk);
            for (int b = 0; b < 16; b++) cnt[b] += int'({uio_out, uo_out}[b]);
        end
        for (int b = 0; b < 16; b++) begin
            if (!m_en[b])              exp = 0;
            else if (!m_pwm[b])        exp = c_PER;
            else if (m_duty == 8'hFF)  exp = c_PER;
            else                       exp = int'(m_duty) * 13;
            chk($sformatf("%s_pin%0d", tag, b), cnt[b], exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        m_en = '0; m_pwm = '0; m_duty = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] bits;
        logic        prev, cur;
        int          n, kind, per, hi, wait_cnt, ones;
        logic [6:0]  addr;
        logic [7:0]  data;

        ena    = 1'b1;
        uio_in = 8'($urandom);
        ui_in  = 8'h04;
        m_en = '0; m_pwm = '0; m_duty = '0;

        // Reset state
        do_reset();
        chk("rst_uo", {24'h0, uo_out}, 32'h00);
        chk("rst_uio", {24'h0, uio_out}, 32'h00);
        chk("rst_oe", {24'h0, uio_oe}, 32'hFF);

        // Static enables
        send_frame(frm(1, 7'h00, 8'hF0), 16);
        chk("en_lo_F0", {24'h0, uo_out}, 32'hF0);
        send_frame(frm(1, 7'h01, 8'hCC), 16);
        chk("en_hi_CC", {24'h0, uio_out}, 32'hCC);
        send_frame(frm(1, 7'h00, 8'h00), 16);
        chk("en_lo_00", {24'h0, uo_out}, 32'h00);
        send_frame(frm(1, 7'h00, 8'h5A), 16);
        check_static("en_lo_5A");

        // Invalid frames leave everything unchanged
        send_frame(frm(1, 7'h30, 8'hFF), 16);
        check_static("bad_addr");
        send_frame(frm(0, 7'h00, 8'hFF), 16);
        check_static("bad_rw");
        send_frame(32'h0000_080F, 12);
        check_static("bad_len12");
        send_frame(32'h0001_01FF, 17);
        check_static("bad_len17");
        chk("invalid_hold", {24'h0, uo_out}, 32'h5A);

        // Randomized frame mix against the model
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 3));
            if (kind < 2) begin
                addr = 7'($urandom_range(0, 4));
                data = 8'($urandom);
                if (addr == 7'd4) begin
                    case ($urandom_range(0, 2))
                        0: data = 8'h00;
                        1: data = 8'hFF;
                        default: ;
                    endcase
                end
                bits = frm(1, addr, data);
                n = 16;
            end else if (kind == 2) begin
                if ($urandom_range(0, 1) == 1) bits = frm(1, 7'($urandom_range(5, 127)), 8'($urandom));
                else                            bits = frm(0, 7'($urandom_range(0, 127)), 8'($urandom));
                n = 16;
            end else begin
                bits = $urandom;
                n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(8, 15))
                                                : int'($urandom_range(17, 20));
            end
            send_frame(bits, n);
            check_static($sformatf("rand%0d", it));
            if (it % 10 == 9) check_counts($sformatf("rcnt%0d", it));
        end

        // PWM frequency and duty at 0x80 on pin 0
        send_frame(frm(1, 7'h01, 8'h00), 16);
        send_frame(frm(1, 7'h03, 8'h00), 16);
        send_frame(frm(1, 7'h00, 8'h01), 16);
        send_frame(frm(1, 7'h02, 8'h01), 16);
        send_frame(frm(1, 7'h04, 8'h80), 16);
        prev = uo_out[0];
        wait_cnt = 0;
        cur = 1'b0;
        while (wait_cnt < 3 * c_PER) begin
            @(negedge clk);
            cur = uo_out[0];
            wait_cnt++;
            if (!prev && cur) break;
            prev = cur;
        end
        if (!(!prev && cur)) begin
            chk("pwm_edge_timeout", 0, 1);
        end else begin
            per = 1; hi = 1; prev = 1'b1;
            while (per < 3 * c_PER) begin
                @(negedge clk);
                cur = uo_out[0];
                if (!prev && cur) break;
                per++;
                hi += int'(cur);
                prev = cur;
            end
            chk("pwm_period", per, c_PER);
            chk("pwm_high", hi, 128 * 13);
        end

        // Duty extremes
        send_frame(frm(1, 7'h04, 8'h00), 16);
        ones = 0;
        for (int t = 0; t < 2 * c_PER; t++) begin
            @(negedge clk);
            ones += int'(uo_out[0]);
        end
        chk("duty00_hold_low", ones, 0);
        send_frame(frm(1, 7'h04, 8'hFF), 16);
        ones = 0;
        for (int t = 0; t < 2 * c_PER; t++) begin
            @(negedge clk);
            ones += int'(uo_out[0]);
        end
        chk("dutyFF_hold_high", ones, 2 * c_PER);

        // Mixed mode on the upper pins
        send_frame(frm(1, 7'h01, 8'hFF), 16);
        send_frame(frm(1, 7'h03, 8'h0F), 16);
        send_frame(frm(1, 7'h04, 8'h40), 16);
        check_counts("mixed");

        // Random mid-range duty
        send_frame(frm(1, 7'h04, 8'($urandom_range(1, 254))), 16);
        check_counts("rduty");

        // Reset during bit 8 of a frame
        send_frame(frm(1, 7'h00, 8'hAA), 16);
        send_frame(frm(1, 7'h02, 8'h00), 16);
        check_static("pre_rst");
        bits = frm(1, 7'h00, 8'hFF);
        ui_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 15; k >= 9; k--) spi_bit(bits[k]);
        ui_in[1] = bits[8];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        m_en = '0; m_pwm = '0; m_duty = '0;
        @(negedge clk);
        chk("midrst_uo", {24'h0, uo_out}, 32'h00);
        chk("midrst_uio", {24'h0, uio_out}, 32'h00);
        for (int k = 7; k >= 0; k--) spi_bit(bits[k]);
        repeat (4) @(negedge clk);
        ui_in[2] = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_partial_uo", {24'h0, uo_out}, 32'h00);
        chk("midrst_partial_uio", {24'h0, uio_out}, 32'h00);

        // Registers work normally after the aborted frame
        send_frame(frm(1, 7'h00, 8'h3C), 16);
        check_static("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uwasic_spi_pwm_peripheral.md
Name: uwasic_spi_pwm_peripheral

Overview:
Top-level user block for the onboarding tile. A write-only SPI peripheral (mode 0) loads five 8-bit configuration registers. A PWM peripheral uses those registers to drive 16 output pins. Pins 0-7 map to uo_out and pins 8-15 map to uio_out. Each pin can be held low, held high, or driven with a PWM waveform of roughly 3 kHz.

Parameters:
PWM_CLK_DIV, 13, system clocks per PWM counter step; at 10 MHz this gives 10e6/(13*256) ≈ 3.0 kHz
NUM_REGS, 5, number of valid register addresses (0x00-0x04)

Ports:
clk  in  1  system clock, 10 MHz nominal
rst_n  in  1  reset: synchronous, active-high (asserted when rst_n=1)
ena  in  1  tile select; ignored
ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
uo_out  out  8  output pins 7:0
uio_in  in  8  unused
uio_out  out  8  output pins 15:8
uio_oe  out  8  constant 8'hFF (all bidirectional pins are outputs)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. On reset, all registers, synchronisers, SPI shift state and PWM counters clear to 0, so uo_out=0 and uio_out=0.
- Register map:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 pwm_en[7:0]
  - 0x03 pwm_en[15:8]
  - 0x04 duty
- Input synchronisation: SCLK, COPI and nCS each pass through a 2-flop synchroniser. A third flop stage is kept for edge detection.
- SPI framing: CPOL=0, CPHA=0, MSB first.
  - A transaction starts on a synchronised nCS falling edge, which clears the bit count and shift register.
  - While nCS=0, COPI is sampled on each synchronised SCLK rising edge.
  - Frame is 16 bits: bit15 = R/W (1=write), bits14:8 = address, bits7:0 = data.
- Commit rule: on the nCS rising edge, the data byte is written to the addressed register only if all three hold:
  - exactly 16 bits were received;
  - R/W=1;
  - address < NUM_REGS.
  Otherwise the frame is discarded and no register changes. Bits after the 16th are counted but make the frame invalid.
- Reads are unsupported; there is no MISO output.
- Timing constraint: SCLK must be at most clk/8 for reliable sampling.
- Reset mid-transaction aborts the frame and clears all registers.
- PWM timebase:
  - A prescaler counts 0..PWM_CLK_DIV-1 and then wraps.
  - On wrap, an 8-bit pwm_cnt increments (255 wraps to 0).
  - pwm_sig = 1 when duty==8'hFF (always high); otherwise pwm_sig = (pwm_cnt < duty).
  - duty=0 therefore gives constant 0.
- Per output bit i (0..15):
  - out[i] = en_out[i] ? (pwm_en[i] ? pwm_sig : 1) : 0.
  - uo_out = out[7:0]; uio_out = out[15:8]. Outputs are registered (one clk after a state change).
- A duty change takes effect on the next comparison, with no period restart. The PWM counter runs continuously regardless of the enable registers.

Test Plan:
1. Reset: hold rst_n=1 for 5 clk cycles, then release -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
2. Static enable:
   - Write 0x00←0xF0 -> uo_out=0xF0.
   - Write 0x01←0xCC -> uio_out=0xCC.
   - Then write 0x00←0x00 -> uo_out=0x00.
3. Invalid frames, each leaving all outputs unchanged:
   - write to address 0x30;
   - frame with R/W=0 to address 0x00, data 0xFF;
   - a 12-bit frame;
   - a 17-bit frame.
4. PWM frequency and duty: write en_out[7:0]=0x01, pwm_en[7:0]=0x01, duty=0x80 -> uo_out[0] period ≈ 3328 clk (3.0 kHz ±1%) and high time 50% ±1%.
5. Duty extremes with PWM enabled:
   - duty=0x00 -> uo_out[0] stays 0 for ≥2 periods.
   - duty=0xFF -> uo_out[0] stays 1 for ≥2 periods.
6. Mixed mode and reset mid-frame:
   - en_out[15:8]=0xFF, pwm_en[15:8]=0x0F, duty=0x40 -> uio_out[7:4]=1 constantly; uio_out[3:0] toggle at 25% duty.
   - Assert reset during bit 8 of a frame -> all outputs return to 0 and the partial frame has no effect.
